// File: rtl/rpn_sequencer.sv
// ---------------------------------------------------------------------------
// rpn_sequencer
//
// Entry sequencer for a push-button RPN calculator. Successive button presses
// capture operand A, operand B and an operator code. The block then starts an
// external ALU, waits for its completion strobe and holds the result. From the
// result display, a further press chains the result into operand A and
// captures the new value as operand B.
//
// Optional feature (compile-time macro): RPN_TIMEOUT_EN
//   Defined   : abandon the ALU wait after TIMEOUT cycles, flag Err, return
//               to operand-A entry.
//   Undefined : wait for AluDone indefinitely.
//
// Parameters
//   WIDTH     operand / result width (>= 3 so opcodes 0..7 are representable)
//   TIMEOUT   cycles allowed in the ALU wait (used only with RPN_TIMEOUT_EN)
//
// Ports
//   Clk        in   1      sole clock, rising edge
//   Rst        in   1      synchronous, active-high reset
//   Btn        in   1      debounced entry button (level)
//   Din        in   WIDTH  value captured on each accepted press
//   AluDone    in   1      ALU completion strobe
//   AluResult  in   WIDTH  ALU result, valid with AluDone
//   OpA        out  WIDTH  first operand register
//   OpB        out  WIDTH  second operand register
//   OpCode     out  WIDTH  operator register
//   AluStart   out  1      one-cycle ALU start pulse
//   Result     out  WIDTH  last accepted ALU result
//   Stage      out  2      entries captured: 0, 1, 2, 3
//   Busy       out  1      high while waiting on the ALU
//   Err        out  1      sticky error flag, cleared by the next good press
// ---------------------------------------------------------------------------
module rpn_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Btn,
    input  logic [WIDTH-1:0] Din,
    input  logic             AluDone,
    input  logic [WIDTH-1:0] AluResult,
    output logic [WIDTH-1:0] OpA,
    output logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] OpCode,
    output logic             AluStart,
    output logic [WIDTH-1:0] Result,
    output logic [1:0]       Stage,
    output logic             Busy,
    output logic             Err
);

    if (WIDTH < 3 || TIMEOUT < 1) begin : g_param_check
        $error("rpn_sequencer: WIDTH must be >= 3 and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_SHOW
    } state_t;

    localparam logic [WIDTH-1:0] OPCODE_MAX = WIDTH'(7);

    state_t           state, state_nx;
    logic             btn_q;       // Btn delayed one cycle
    logic             armed;       // Btn has been seen low since reset
    logic             press;
    logic             done_seen;   // AluDone outside the AluStart cycle
    logic [WIDTH-1:0] opa_nx, opb_nx, opcode_nx, result_nx;
    logic             start_nx, err_nx;

    // A button held through reset release must fall before it can count, so
    // edge detection is gated until Btn has been observed low once.
    assign press     = Btn & ~btn_q & armed;
    assign done_seen = AluDone & ~AluStart;

`ifdef RPN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] exec_cnt;
    logic             timed_out;

    // exec_cnt is 0 in the first wait cycle, so it reaches TIMEOUT-1 in the
    // last permitted cycle; AluDone in that same cycle takes priority.
    assign timed_out = (exec_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            exec_cnt <= '0;
        end else if (state == S_EXEC && state_nx == S_EXEC) begin
            exec_cnt <= exec_cnt + CNT_W'(1);
        end else begin
            exec_cnt <= '0;
        end
    end
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_A;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default before the case; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nx  = state;
        opa_nx    = OpA;
        opb_nx    = OpB;
        opcode_nx = OpCode;
        result_nx = Result;
        err_nx    = Err;
        start_nx  = 1'b0;

        case (state)
            S_A: begin
                if (press) begin
                    opa_nx   = Din;
                    err_nx   = 1'b0;
                    state_nx = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    opb_nx   = Din;
                    err_nx   = 1'b0;
                    state_nx = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    if (Din <= OPCODE_MAX) begin
                        opcode_nx = Din;
                        err_nx    = 1'b0;
                        start_nx  = 1'b1;
                        state_nx  = S_EXEC;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                // Presses are deliberately ignored while the ALU is running.
                if (done_seen) begin
                    result_nx = AluResult;
                    state_nx  = S_SHOW;
                end
`ifdef RPN_TIMEOUT_EN
                else if (timed_out) begin
                    err_nx   = 1'b1;
                    state_nx = S_A;
                end
`endif
            end
            S_SHOW: begin
                if (press) begin
                    opa_nx   = Result;
                    opb_nx   = Din;
                    err_nx   = 1'b0;
                    state_nx = S_OP;
                end
            end
            default: state_nx = S_A;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            OpA      <= '0;
            OpB      <= '0;
            OpCode   <= '0;
            Result   <= '0;
            AluStart <= 1'b0;
            Err      <= 1'b0;
            btn_q    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            OpA      <= opa_nx;
            OpB      <= opb_nx;
            OpCode   <= opcode_nx;
            Result   <= result_nx;
            AluStart <= start_nx;
            Err      <= err_nx;
            btn_q    <= Btn;
            armed    <= armed | ~Btn;
        end
    end

    always_comb begin
        case (state)
            S_A:     Stage = 2'd0;
            S_B:     Stage = 2'd1;
            S_OP:    Stage = 2'd2;
            default: Stage = 2'd3;
        endcase
    end

    assign Busy = (state == S_EXEC);

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles waiting for AluDone (used only with RPN_TIMEOUT_EN).
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Btn  input  1  debounced entry button, synchronous level.
REQ-006 SHALL have port Din  input  WIDTH  value captured on each accepted press.
REQ-007 SHALL have port AluDone  input  1  ALU completion strobe.
REQ-008 SHALL have port AluResult  input  WIDTH  ALU result, valid with AluDone.
REQ-009 SHALL have port OpA  output  WIDTH  first operand register.
REQ-010 SHALL have port OpB  output  WIDTH  second operand register.
REQ-011 SHALL have port OpCode  output  WIDTH  operator register.
REQ-012 SHALL have port AluStart  output  1  one-cycle ALU start pulse.
REQ-013 SHALL have port Result  output  WIDTH  last accepted ALU result.
REQ-014 SHALL have port Stage  output  2  entries captured: 0, 1, 2, 3.
REQ-015 SHALL have port Busy  output  1  high while waiting on ALU.
REQ-016 SHALL have port Err  output  1  sticky error flag.

Function
REQ-017 SHALL detect press = Btn high and registered previous Btn low; one press per rising edge, level hold ignored.
REQ-018 SHALL implement states S_A, S_B, S_OP, S_EXEC, S_SHOW; Stage = 0, 1, 2, 3, 3 respectively.
REQ-019 S_A: press SHALL load OpA<=Din, go S_B.
REQ-020 S_B: press SHALL load OpB<=Din, go S_OP.
REQ-021 S_OP: press with Din<=7 SHALL load OpCode<=Din, go S_EXEC, assert AluStart in the first S_EXEC cycle only.
REQ-022 S_OP: press with Din>7 SHALL set Err=1, leave OpCode unchanged, stay S_OP.
REQ-023 S_EXEC: Busy=1; AluDone SHALL be ignored in the AluStart cycle and sampled every later cycle.
REQ-024 S_EXEC: sampled AluDone SHALL load Result<=AluResult, go S_SHOW, Busy=0 next cycle; AluStart never re-asserted.
REQ-025 S_EXEC: presses SHALL be ignored (no capture, no flag).
REQ-026 S_SHOW: press SHALL load OpA<=Result, OpB<=Din, go S_OP (RPN chaining).
REQ-027 Any accepted press SHALL clear Err in the same update, except REQ-022, which sets it.
REQ-028 Latency: press-to-register update 1 cycle; valid opcode press to AluStart 1 cycle.

Reset
REQ-029 Rst high SHALL, at the next Clk edge, set state S_A, OpA=OpB=OpCode=Result=0, Stage=0, AluStart=0, Busy=0, Err=0, press-detect register=0.
REQ-030 Rst SHALL override all events in the same cycle, including mid-S_EXEC; a later AluDone SHALL be ignored in S_A.
REQ-031 Btn held high through reset release SHALL NOT produce a press until it falls and rises again.

Configuration
REQ-032 With RPN_TIMEOUT_EN defined: cycle counter cleared on S_EXEC entry; if TIMEOUT cycles elapse in S_EXEC without AluDone, SHALL set Err=1, keep Result, go S_A, Busy=0; AluDone in the timeout cycle wins.
REQ-033 Without RPN_TIMEOUT_EN: no counter; S_EXEC waits indefinitely for AluDone.

Verification
REQ-034 Reset, presses Din=0x05, 0x03, 0x01; AluDone with 0x08 three cycles after AluStart -> OpA=0x05, OpB=0x03, OpCode=0x01, single AluStart, Result=0x08, Stage=3, Busy=0.
REQ-035 In S_SHOW, Result=0x08, press Din=0x02 -> OpA=0x08, OpB=0x02, Stage=2.
REQ-036 In S_OP, press Din=0x09 -> Err=1, Stage=2; then press Din=0x00 -> Err=0, AluStart one cycle.
REQ-037 Btn held high 10 cycles in S_A -> exactly one capture; presses during S_EXEC -> no register change.
REQ-038 Rst asserted during S_EXEC, AluDone 2 cycles later -> all outputs 0, state S_A, Result stays 0.
REQ-039 RPN_TIMEOUT_EN, TIMEOUT=15, no AluDone -> Err=1, Stage=0, Busy=0 after 15 S_EXEC cycles; without macro Busy stays 1.
